ap_chain_rf_model: RTL and testbench
====================================

AP_CHAIN_RF_MODEL -- requirements
Module: ap_chain_rf_model

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and set the register data and ap_return width.
REQ-002 The parameter DEPTH SHALL default to 32 and set the number of registers, which SHALL be at least 2.
REQ-003 The parameter ADDR_W SHALL default to 32 and set the width of the addr port.
REQ-004 The parameter RD_LAT SHALL default to 1 and set the read latency in enabled cycles, which SHALL be at least 1.
REQ-005 The parameter WR_LAT SHALL default to 2 and set the write latency in enabled cycles, which SHALL be at least 1.
REQ-006 clk SHALL be an input of width 1 and be the single clock.
REQ-007 ap_rst SHALL be an input of width 1 and be the reset, synchronous and active-high.
REQ-008 ap_ce SHALL be an input of width 1 and act as the clock enable.
REQ-009 ap_start, ap_continue and rd_wr SHALL be inputs of width 1; rd_wr=1 means read and rd_wr=0 means write.
REQ-010 addr (ADDR_W bits) and wr_data (DATA_W bits) SHALL be inputs.
REQ-011 ap_idle, ap_ready, ap_done and ap_err SHALL be outputs of width 1, and ap_return SHALL be an output of DATA_W bits.

Function
REQ-012 The FSM SHALL have exactly four states: RST, IDLE, BUSY and DONE.
REQ-013 When ap_ce=0, every state bit, the counter, the registers and ap_return SHALL hold their values, and ap_ready SHALL be 0.
REQ-014 Accept SHALL be defined as ap_ce=1 AND ap_start=1 AND either state=IDLE, or state=DONE with ap_continue=1.
REQ-015 On accept, ap_ready SHALL be 1 combinationally in that cycle; addr, wr_data and rd_wr SHALL be latched; the counter SHALL load (rd_wr ? RD_LAT : WR_LAT)-1; and the next state SHALL be BUSY.
REQ-016 In BUSY, the counter SHALL decrement on each enabled cycle, and the FSM SHALL move to DONE on the enabled cycle in which the counter is 0.
REQ-017 ap_done SHALL therefore first assert exactly LAT enabled cycles after the accept edge.
REQ-018 A latched write with latched addr < DEPTH SHALL commit to the register array on the BUSY-to-DONE edge.
REQ-019 A latched read with latched addr < DEPTH SHALL load ap_return from the array on the BUSY-to-DONE edge, reflecting every previously completed write.
REQ-020 A latched addr >= DEPTH SHALL drop the write or load 0 into ap_return, and SHALL set ap_err; ap_err SHALL clear at the next accept.
REQ-021 ap_return SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-022 In DONE, ap_done SHALL stay 1 until an enabled cycle with ap_continue=1.
REQ-023 In DONE with ap_continue=1 and no accept, the next state SHALL be IDLE.
REQ-024 In DONE with ap_continue=1 and an accept, the next state SHALL be BUSY directly (back-to-back chaining, no IDLE cycle).
REQ-025 ap_idle SHALL be 1 only in IDLE with ap_start=0.
REQ-026 ap_done SHALL be 1 only in DONE.
REQ-027 In RST, all handshake outputs SHALL be 0.
REQ-028 In IDLE, ap_start with ap_ce=0 SHALL neither accept nor drop the request; it SHALL be sampled again on the next enabled cycle.
REQ-029 An illegal state encoding SHALL transition to RST.

Reset
REQ-030 When ap_rst=1, regardless of ap_ce, the state SHALL become RST, and the counter, ap_return, ap_err and all registers SHALL become 0.
REQ-031 RST SHALL last one enabled cycle and then transition to IDLE.
REQ-032 Reset asserted while in BUSY SHALL abort the operation, with no commit and no ap_done.

Structure
REQ-033 Package ap_chain_pkg SHALL hold the state encodings, the default parameter values and the rd/wr encoding constants.
REQ-034 The register array, with one write port, one read port and synchronous clear, SHALL be the sub-module ap_chain_rf_regs; the FSM and counter SHALL stay in the top level.

Verification
REQ-035 With RD_LAT=1 and WR_LAT=2: write 0xDEADBEEF to addr 3, then read addr 3 -> ap_done at +2 and +1 enabled cycles respectively, and ap_return=0xDEADBEEF.
REQ-036 Hold ap_continue=0 for 5 cycles in DONE -> ap_done stays 1 and ap_idle stays 0 throughout; the first ap_continue=1 returns the FSM to IDLE.
REQ-037 Chaining: in DONE, assert ap_continue=1 and ap_start=1 with a read of addr 3 -> ap_ready=1 that cycle, no ap_idle pulse, and the read completes with 0xDEADBEEF.
REQ-038 Write to addr=DEPTH -> ap_err=1 with ap_done, no register changes, and a subsequent read of addr=DEPTH returns 0 with ap_err=1.
REQ-039 Toggle ap_ce=0 for 3 cycles mid-BUSY with WR_LAT=4 -> ap_done first asserts after exactly 4 enabled cycles.
REQ-040 Assert ap_rst during BUSY of a write of 0x5 to addr 1 -> the write is not committed, a read of addr 1 returns 0, and ap_idle=1 two cycles after reset release.

Source files
------------

// File: rtl/ap_chain_pkg.sv
// Shared definitions for the ap_chain register-file model: FSM encodings,
// default parameter values and the rd_wr encoding.
package ap_chain_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_WR_LAT = 2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ap_chain_rf_regs.sv
// Register array with one write port, one combinational read port and a
// synchronous clear that wins over writes.
module ap_chain_rf_regs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ap_chain_rf_model.sv
// ap_ctrl_chain style register file: one read or write per start, completing
// after a fixed number of enabled cycles, with back-to-back chaining from DONE.
module ap_chain_rf_model
  import ap_chain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int WR_LAT = DEF_WR_LAT
) (
  input  logic              clk,
  input  logic              ap_rst,
  input  logic              ap_ce,
  input  logic              ap_start,
  input  logic              ap_continue,
  input  logic              rd_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_err,
  output logic [DATA_W-1:0] ap_return
);

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int IDX_W   = $clog2(DEPTH);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_rw;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic                accept;
  logic                in_range;
  logic                finish;
  logic                reg_we;
  logic [DATA_W-1:0]   rd_data;

  assign accept = ap_ce && !ap_rst && ap_start &&
                  ((state == ST_IDLE) || ((state == ST_DONE) && ap_continue));
  assign in_range = (lat_addr < ADDR_W'(DEPTH));
  // The last enabled BUSY cycle is the one that commits or loads ap_return.
  assign finish   = ap_ce && !ap_rst && (state == ST_BUSY) && (cnt == '0);
  assign reg_we   = finish && (lat_rw == RW_WRITE) && in_range;

  assign ap_ready = accept;
  assign ap_idle  = (state == ST_IDLE) && !ap_start;
  assign ap_done  = (state == ST_DONE);

  ap_chain_rf_regs #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regs (
    .clk   (clk),
    .clr   (ap_rst),
    .we    (reg_we),
    .waddr (lat_addr[IDX_W-1:0]),
    .wdata (lat_data),
    .raddr (lat_addr[IDX_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state     <= ST_RST;
      cnt       <= '0;
      lat_rw    <= RW_WRITE;
      lat_addr  <= '0;
      lat_data  <= '0;
      ap_err    <= 1'b0;
      ap_return <= '0;
    end else if (ap_ce) begin
      if (accept) begin
        lat_rw   <= rd_wr;
        lat_addr <= addr;
        lat_data <= wr_data;
        cnt      <= (rd_wr == RW_READ) ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
        ap_err   <= 1'b0;
      end
      case (state)
        ST_RST:  state <= ST_IDLE;
        ST_IDLE: if (accept) state <= ST_BUSY;
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            if (!in_range) ap_err <= 1'b1;
            if (lat_rw == RW_READ) ap_return <= in_range ? rd_data : '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (accept)           state <= ST_BUSY;
          else if (ap_continue) state <= ST_IDLE;
        end
        default: state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_chain_rf_model.sv
// Randomized transaction bench for ap_chain_rf_model against an array-based
// reference; a second instance covers clock-enable gaps with a longer write latency.
module tb_ap_chain_rf_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ap_rst, ap_ce, ap_start, ap_continue, rd_wr;
  logic [31:0] addr, wr_data;
  logic        ap_idle, ap_ready, ap_done, ap_err;
  logic [31:0] ap_return;

  logic        b_ap_rst, b_ap_ce, b_ap_start, b_ap_continue, b_rd_wr;
  logic [31:0] b_addr, b_wr_data;
  logic        b_ap_idle, b_ap_ready, b_ap_done, b_ap_err;
  logic [31:0] b_ap_return;

  ap_chain_rf_model dut (
    .clk(clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
    .ap_continue(ap_continue), .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done), .ap_err(ap_err),
    .ap_return(ap_return)
  );

  ap_chain_rf_model #(.DEPTH(8), .WR_LAT(4)) dut_b (
    .clk(clk), .ap_rst(b_ap_rst), .ap_ce(b_ap_ce), .ap_start(b_ap_start),
    .ap_continue(b_ap_continue), .rd_wr(b_rd_wr), .addr(b_addr), .wr_data(b_wr_data),
    .ap_idle(b_ap_idle), .ap_ready(b_ap_ready), .ap_done(b_ap_done), .ap_err(b_ap_err),
    .ap_return(b_ap_return)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [32];
  logic [31:0] ret_m;
  logic        err_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    ret_m = '0;
    err_m = 1'b0;
  endtask

  // One full transaction from IDLE (or from DONE when chained) to DONE,
  // then 'hold' cycles parked in DONE with ap_continue low.
  task automatic run_op(input bit rw, input logic [31:0] a, input logic [31:0] d,
                        input bit chained, input int hold);
    int lat;
    int n;
    ap_start    = 1'b1;
    rd_wr       = rw;
    addr        = a;
    wr_data     = d;
    ap_continue = chained;
    while ($urandom_range(0, 3) == 0) begin
      ap_ce = 1'b0;
      #1 chk("ready_stalled", ap_ready, 0);
      tick();
    end
    ap_ce = 1'b1;
    #1;
    chk("ready", ap_ready, 1);
    chk("idle_at_accept", ap_idle, 0);
    tick();
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    rd_wr       = $urandom_range(0, 1);
    addr        = $urandom;
    wr_data     = $urandom;
    lat = 0;
    n   = 0;
    while (!ap_done && n < 200) begin
      ap_ce = ($urandom_range(0, 3) != 0);
      tick();
      if (ap_ce) lat++;
      n++;
    end
    chk("done", ap_done, 1);
    chk("latency", lat, rw ? 1 : 2);
    err_m = (a >= 32);
    if (rw) ret_m = (a < 32) ? mem_m[a] : 32'h0;
    else if (a < 32) mem_m[a] = d;
    chk("return", ap_return, ret_m);
    chk("err", ap_err, err_m);
    chk("idle_in_done", ap_idle, 0);
    repeat (hold) begin
      ap_ce = $urandom_range(0, 1);
      tick();
      chk("hold_done", ap_done, 1);
      chk("hold_idle", ap_idle, 0);
    end
  endtask

  task automatic release_done();
    ap_ce       = 1'b1;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    chk("release_done", ap_done, 0);
    chk("release_idle", ap_idle, 1);
  endtask

  initial begin
    bit ch;
    bit ch_next;
    int lat;
    int pat [8] = '{1, 0, 0, 0, 1, 1, 1, 1};

    ap_rst = 1'b1; ap_ce = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    rd_wr = 1'b0; addr = '0; wr_data = '0;
    b_ap_rst = 1'b1; b_ap_ce = 1'b0; b_ap_start = 1'b0; b_ap_continue = 1'b0;
    b_rd_wr = 1'b0; b_addr = '0; b_wr_data = '0;
    model_clear();

    tick();
    tick();
    chk("rst_done", ap_done, 0);
    chk("rst_idle", ap_idle, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_err", ap_err, 0);
    chk("rst_return", ap_return, 0);
    ap_rst = 1'b0;
    ap_ce  = 1'b1;
    tick();
    chk("post_rst_idle", ap_idle, 1);

    // Directed: write/read, parked DONE, chained read, out-of-range access.
    run_op(1'b0, 32'd3, 32'hDEADBEEF, 1'b0, 0);
    release_done();
    run_op(1'b1, 32'd3, 32'h0, 1'b0, 5);
    release_done();
    run_op(1'b1, 32'd3, 32'h0, 1'b0, 0);
    run_op(1'b1, 32'd3, 32'h0, 1'b1, 0);
    release_done();
    run_op(1'b0, 32'd32, 32'hCAFEF00D, 1'b0, 0);
    release_done();
    run_op(1'b1, 32'd32, 32'h0, 1'b0, 0);
    release_done();

    ch = 1'b0;
    for (int i = 0; i < 80; i++) begin
      run_op($urandom_range(0, 1), $urandom_range(0, 39), $urandom, ch, $urandom_range(0, 3));
      ch_next = $urandom_range(0, 1);
      if (!ch_next) release_done();
      ch = ch_next;
    end
    if (ch) release_done();

    // Reset in the middle of a write must abort it.
    ap_ce = 1'b1; ap_start = 1'b1; rd_wr = 1'b0; addr = 32'd1; wr_data = 32'h5;
    tick();
    ap_start = 1'b0;
    ap_rst   = 1'b1;
    tick();
    chk("abort_done", ap_done, 0);
    ap_rst = 1'b0;
    tick();
    tick();
    chk("abort_idle", ap_idle, 1);
    model_clear();
    run_op(1'b1, 32'd1, 32'h0, 1'b0, 0);
    release_done();

    // WR_LAT=4 instance: enable gaps must not count toward latency.
    tick();
    b_ap_rst = 1'b0;
    b_ap_ce  = 1'b1;
    tick();
    b_ap_start = 1'b1; b_rd_wr = 1'b0; b_addr = 32'd2; b_wr_data = 32'h1234;
    #1 chk("b_ready", b_ap_ready, 1);
    tick();
    b_ap_start = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      if (!b_ap_done) begin
        b_ap_ce = pat[k][0];
        tick();
        if (b_ap_ce) lat++;
        chk("b_done_timing", b_ap_done, lat >= 4);
      end
    end
    chk("b_latency", lat, 4);
    b_ap_ce = 1'b1; b_ap_continue = 1'b1;
    tick();
    b_ap_continue = 1'b0;
    chk("b_idle", b_ap_idle, 1);
    b_ap_start = 1'b1; b_rd_wr = 1'b1; b_addr = 32'd2;
    tick();
    b_ap_start = 1'b0;
    tick();
    chk("b_read_done", b_ap_done, 1);
    chk("b_read_return", b_ap_return, 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
